// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: shared types for the DMA command scheduler.
package ahb3lite_pkg;
    localparam int DMA_LEN_W = 6;
    // Widest requester id (NUM_REQ up to 4); narrower configurations zero-extend.
    localparam int CMD_ID_W = 2;

    typedef struct packed {
        logic [15:0]           addr_high;
        logic [15:0]           addr_low;
        logic [DMA_LEN_W-1:0]  len;
        logic [CMD_ID_W-1:0]   id;
    } dma_cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY} sched_state_e;
endpackage

// File: rtl/dma_cmd_fifo.sv
// dma_cmd_fifo: registered command FIFO, wrap-bit pointers, no bypass.
module dma_cmd_fifo
    import ahb3lite_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  dma_cmd_t                 din,
    input  logic                     pop,
    output dma_cmd_t                 dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    dma_cmd_t       mem [DEPTH];
    logic [AW:0]    wr, rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd[AW-1:0]];
    assign empty = wr == rd;
    assign full  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign level = wr - rd;
endmodule

// File: rtl/dma_cmd_scheduler.sv
// dma_cmd_scheduler: round-robin arbitration of requester commands into a FIFO,
// launched one at a time onto the DMA master command channel.
module dma_cmd_scheduler
    import ahb3lite_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int IDW        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           HCLK,
    input  logic                           HRESET,
    input  logic                           SystemStart,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*16-1:0]          req_addr_high,
    input  logic [NUM_REQ*16-1:0]          req_addr_low,
    input  logic [NUM_REQ*DMA_LEN_W-1:0]   req_len,
    output logic [NUM_REQ-1:0]             req_done,
    input  logic                           Master_Done,
    output logic                           NewCommandOn,
    output logic [DMA_LEN_W-1:0]           o_RCC_BUFFER_LENGTH,
    output logic [15:0]                    o_RCC_DMA_ADDR_HIGH,
    output logic [15:0]                    o_RCC_DMA_ADDR_LOW,
    output logic [IDW-1:0]                 o_active_id,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);
    logic [IDW-1:0]       rr, gnt_id;
    logic                 gnt, hit, full, empty, pop;
    logic [CMD_ID_W-1:0]  act_id;
    dma_cmd_t             push_cmd, head;
    sched_state_e         state, state_nx;

    // Descending scan so the nearest valid requester at or after rr wins.
    always_comb begin
        hit    = 1'b0;
        gnt_id = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr) + k) % NUM_REQ]) begin
                hit    = 1'b1;
                gnt_id = IDW'((int'(rr) + k) % NUM_REQ);
            end
        end
    end

    assign gnt       = hit && !full && !HRESET;
    assign req_ready = gnt ? (NUM_REQ'(1) << gnt_id) : '0;
    assign push_cmd  = '{addr_high: req_addr_high[16*gnt_id +: 16],
                         addr_low:  req_addr_low[16*gnt_id +: 16],
                         len:       req_len[DMA_LEN_W*gnt_id +: DMA_LEN_W],
                         id:        CMD_ID_W'(gnt_id)};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) rr <= '0;
        else if (gnt) rr <= (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
    end

    dma_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (gnt),
        .din   (push_cmd),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= S_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            S_IDLE: begin
                pop      = !empty && SystemStart;
                state_nx = pop ? S_LAUNCH : S_IDLE;
            end
            S_LAUNCH: state_nx = (o_RCC_BUFFER_LENGTH != '0) ? S_BUSY : S_IDLE;
            S_BUSY:   state_nx = Master_Done ? S_IDLE : S_BUSY;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            NewCommandOn        <= 1'b0;
            req_done            <= '0;
            o_RCC_BUFFER_LENGTH <= '0;
            o_RCC_DMA_ADDR_HIGH <= '0;
            o_RCC_DMA_ADDR_LOW  <= '0;
            act_id              <= '0;
        end else begin
            req_done <= '0;
            if (pop) begin
                o_RCC_BUFFER_LENGTH <= head.len;
                o_RCC_DMA_ADDR_HIGH <= head.addr_high;
                o_RCC_DMA_ADDR_LOW  <= head.addr_low;
                act_id              <= head.id;
            end
            // Zero-length commands complete without ever reaching the master.
            if (state == S_LAUNCH && o_RCC_BUFFER_LENGTH != '0) NewCommandOn <= 1'b1;
            if (state == S_LAUNCH && o_RCC_BUFFER_LENGTH == '0) req_done <= NUM_REQ'(1) << act_id;
            if (state == S_BUSY && Master_Done) begin
                NewCommandOn <= 1'b0;
                req_done     <= NUM_REQ'(1) << act_id;
            end
        end
    end

    assign o_active_id = act_id[IDW-1:0];
endmodule

// File: tb/tb_dma_cmd_scheduler.sv
// tb_dma_cmd_scheduler: directed stimulus with a queue scoreboard checked by
// an independent monitor on launches and completion pulses.
module tb_dma_cmd_scheduler;
    localparam int NR = 2;

    logic              HCLK = 1'b0, HRESET = 1'b0, SystemStart = 1'b0, Master_Done = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready, req_done;
    logic [NR*16-1:0]  req_addr_high = '0, req_addr_low = '0;
    logic [NR*6-1:0]   req_len = '0;
    logic              NewCommandOn;
    logic [5:0]        o_len;
    logic [15:0]       o_hi, o_lo;
    logic [0:0]        o_active_id;
    logic [2:0]        fifo_level;

    int   checks = 0, errors = 0, auto_lat = 0, cnt = 0, lvl_at_hs = 0;
    logic kick = 1'b0, nco_q = 1'b0;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic [5:0]  len;
        int          id;
    } cmd_t;

    cmd_t exp_launch[$];
    int   exp_done[$];
    cmd_t mc;

    dma_cmd_scheduler #(.NUM_REQ(NR), .FIFO_DEPTH(4)) dut (
        .HCLK                (HCLK),
        .HRESET              (HRESET),
        .SystemStart         (SystemStart),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_addr_high       (req_addr_high),
        .req_addr_low        (req_addr_low),
        .req_len             (req_len),
        .req_done            (req_done),
        .Master_Done         (Master_Done),
        .NewCommandOn        (NewCommandOn),
        .o_RCC_BUFFER_LENGTH (o_len),
        .o_RCC_DMA_ADDR_HIGH (o_hi),
        .o_RCC_DMA_ADDR_LOW  (o_lo),
        .o_active_id         (o_active_id),
        .fifo_level          (fifo_level)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int id, input logic [15:0] hi, input logic [15:0] lo, input logic [5:0] len);
        req_addr_high[16*id +: 16] = hi;
        req_addr_low[16*id +: 16]  = lo;
        req_len[6*id +: 6]         = len;
        req_valid[id]              = 1'b1;
    endtask

    task automatic expect_cmd(input int id);
        cmd_t c;
        c.hi  = req_addr_high[16*id +: 16];
        c.lo  = req_addr_low[16*id +: 16];
        c.len = req_len[6*id +: 6];
        c.id  = id;
        if (c.len != 0) exp_launch.push_back(c);
        exp_done.push_back(id);
    endtask

    task automatic handshake(input int id, input int limit);
        int n = 0;
        @(negedge HCLK);
        while (!req_ready[id] && n < limit) begin
            n++;
            @(negedge HCLK);
        end
        chk($sformatf("ready%0d", id), int'(req_ready[id]), 1);
        if (req_ready[id]) begin
            lvl_at_hs = int'(fifo_level);
            expect_cmd(id);
        end
        @(posedge HCLK);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (!(exp_launch.size() == 0 && exp_done.size() == 0 && !NewCommandOn && fifo_level == 0) && n < limit);
        chk("drain", int'(n < limit), 1);
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
    endtask

    // Master model: acknowledges after auto_lat busy cycles, or once on kick.
    always @(posedge HCLK) begin
        #1;
        if (HRESET || !NewCommandOn) cnt = 0;
        else cnt++;
        Master_Done = kick || (auto_lat != 0 && cnt == auto_lat);
        kick = 1'b0;
    end

    always @(negedge HCLK) begin
        if (NewCommandOn && !nco_q) begin
            if (exp_launch.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL launch: unexpected command id %0d len %0d", o_active_id, o_len);
            end else begin
                mc = exp_launch.pop_front();
                chk("launch_hi", int'(o_hi), int'(mc.hi));
                chk("launch_lo", int'(o_lo), int'(mc.lo));
                chk("launch_len", int'(o_len), int'(mc.len));
                chk("launch_id", int'(o_active_id), mc.id);
            end
        end
        nco_q = NewCommandOn;
        if (req_done != '0) begin
            if (exp_done.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done: unexpected req_done 0x%0h", req_done);
            end else chk("done", int'(req_done), 1 << exp_done.pop_front());
        end
    end

    initial begin
        #1 HRESET = 1'b1;
        @(negedge HCLK);
        req_valid = 2'b01;
        #1;
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_nco", int'(NewCommandOn), 0);
        chk("rst_done", int'(req_done), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_out", int'({o_hi, o_lo} | 32'(o_len) | 32'(o_active_id)), 0);
        req_valid = '0;
        @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Single command
        SystemStart = 1'b1;
        auto_lat = 10;
        drive(0, 16'h1234, 16'h5678, 6'd8);
        handshake(0, 3);
        chk("t1_level_push", int'(fifo_level), 1);
        @(posedge HCLK);
        #1;
        chk("t1_level_pop", int'(fifo_level), 0);
        chk("t1_nco_pre", int'(NewCommandOn), 0);
        chk("t1_hi_pre", int'(o_hi), 'h1234);
        chk("t1_lo_pre", int'(o_lo), 'h5678);
        chk("t1_len_pre", int'(o_len), 8);
        @(posedge HCLK);
        #1;
        chk("t1_nco_rise", int'(NewCommandOn), 1);
        wait_idle(40);

        // Round robin into a full FIFO with launches gated
        do_reset();
        SystemStart = 1'b0;
        auto_lat = 2;
        drive(0, 16'hA000, 16'h0001, 6'd3);
        drive(1, 16'hB000, 16'h0002, 6'd5);
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            chk("rr_grant", int'(req_ready), (k % 2 == 0) ? 1 : 2);
            expect_cmd(k % 2);
            @(posedge HCLK);
            #1;
        end
        @(negedge HCLK);
        chk("rr_full_ready", int'(req_ready), 0);
        chk("rr_full_level", int'(fifo_level), 4);
        @(posedge HCLK);
        #1;
        req_valid = '0;
        SystemStart = 1'b1;
        wait_idle(200);

        // SystemStart gating with a zero-length command first
        SystemStart = 1'b0;
        auto_lat = 4;
        drive(1, 16'h0C0C, 16'h0D0D, 6'd0);
        handshake(1, 5);
        drive(0, 16'h0E0E, 16'h0F0F, 6'd6);
        handshake(0, 5);
        repeat (3) @(posedge HCLK);
        #1;
        chk("gate_nco", int'(NewCommandOn), 0);
        chk("gate_level", int'(fifo_level), 2);
        SystemStart = 1'b1;
        @(posedge HCLK);
        #1;
        chk("zl_pop_level", int'(fifo_level), 1);
        chk("zl_len", int'(o_len), 0);
        chk("zl_id", int'(o_active_id), 1);
        @(posedge HCLK);
        #1;
        chk("zl_done", int'(req_done), 2);
        chk("zl_nco", int'(NewCommandOn), 0);
        wait_idle(100);

        // Full FIFO, completion frees a slot for a waiting requester
        auto_lat = 0;
        drive(0, 16'h1000, 16'h0000, 6'd1);
        handshake(0, 3);
        for (int k = 1; k < 5; k++) begin
            drive(0, 16'h1000 + 16'(k), 16'(k), 6'(k + 1));
            handshake(0, 3);
        end
        drive(0, 16'h2000, 16'h0055, 6'd9);
        @(negedge HCLK);
        chk("ff_ready", int'(req_ready), 0);
        chk("ff_level", int'(fifo_level), 4);
        chk("ff_busy", int'(NewCommandOn), 1);
        kick = 1'b1;
        handshake(0, 20);
        chk("ff_level_at_push", lvl_at_hs, 3);
        chk("ff_level_after", int'(fifo_level), 4);
        auto_lat = 3;
        wait_idle(300);

        // Reset during a transfer
        auto_lat = 0;
        drive(1, 16'h3333, 16'h4444, 6'd9);
        handshake(1, 3);
        drive(0, 16'h5555, 16'h6666, 6'd7);
        handshake(0, 3);
        begin
            int n = 0;
            while (!NewCommandOn && n < 10) begin
                n++;
                @(negedge HCLK);
            end
            chk("mid_busy", int'(NewCommandOn), 1);
        end
        @(negedge HCLK);
        HRESET = 1'b1;
        #1;
        chk("mr_nco", int'(NewCommandOn), 0);
        chk("mr_level", int'(fifo_level), 0);
        chk("mr_done", int'(req_done), 0);
        chk("mr_out", int'({o_hi, o_lo} | 32'(o_len)), 0);
        exp_launch.delete();
        exp_done.delete();
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
        repeat (5) @(posedge HCLK);
        #1;
        chk("post_nco", int'(NewCommandOn), 0);
        chk("post_level", int'(fifo_level), 0);
        chk("post_ready", int'(req_ready), 0);
        chk("left_launch", exp_launch.size(), 0);
        chk("left_done", exp_done.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dma_cmd_scheduler.md
# dma_cmd_scheduler

Arbitrates DMA command requests from several register-file requesters and queues them in a small command FIFO. It sequences the queued commands one at a time onto the single AHB-Lite DMA master command channel. Each command is held stable for its whole transfer, and the owning requester is told when its command has finished. The block sits between the CPU-side command register banks and the AHB-Lite master, and replaces their direct connection to it.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- FIFO_DEPTH, 4, command FIFO entries (power of 2)
- IDW, derived, max(1,$clog2(NUM_REQ)), requester-id width

- HCLK  in  1  clock, rising edge
- HRESET  in  1  asynchronous, active-high reset
- SystemStart  in  1  global launch enable; level-sensitive
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero, combinational
- req_addr_high  in  NUM_REQ*16  packed, requester i at [16i+15:16i]
- req_addr_low  in  NUM_REQ*16  packed, same layout
- req_len  in  NUM_REQ*6  packed buffer length in beats
- req_done  out  NUM_REQ  one-cycle completion pulse to the owner
- Master_Done  in  1  master finished the current command (pulse)
- NewCommandOn  out  1  command valid to the master; high for the whole transfer
- o_RCC_BUFFER_LENGTH  out  6  current command length
- o_RCC_DMA_ADDR_HIGH  out  16  current command address [31:16]
- o_RCC_DMA_ADDR_LOW  out  16  current command address [15:0]
- o_active_id  out  IDW  requester owning the current command
- fifo_level  out  $clog2(FIFO_DEPTH)+1  queued entries

## Operation
- **Reset (async):** the FIFO is emptied and the RR pointer goes to 0. All outputs are 0, and the FSM is in IDLE.
- **Arbitration:**
  - Each cycle the FIFO is not full at cycle start, req_ready is set for the first valid requester at or after the RR pointer, searching cyclically.
  - A transfer happens when req_valid[i] & req_ready[i]. The command {addr_high, addr_low, len, id=i} is pushed on that edge.
  - The RR pointer then moves to i+1 mod NUM_REQ. With no transfer, the pointer holds.
  - When the FIFO is full, req_ready is all 0.
- **FSM:**
  - IDLE → LAUNCH when the FIFO is not empty and SystemStart=1. On this edge the head entry is popped into the o_RCC_* outputs and o_active_id.
  - LAUNCH, if len≠0: NewCommandOn←1, go to BUSY.
  - LAUNCH, if len==0: no master command. req_done[id] pulses, go to IDLE.
  - BUSY: outputs are held. On Master_Done=1: NewCommandOn←0, req_done[id] pulses for one cycle, go to IDLE.
- Master_Done is ignored outside BUSY.
- SystemStart low during BUSY does not abort the command. It only blocks the next launch.
- A push and a pop may occur on the same edge. fifo_level is then unchanged.
- A push while full is impossible, because req_ready is 0.
- Wrap-around: the read and write pointers are log2(FIFO_DEPTH) bits plus one wrap bit. full = same index with different wrap bit.
- The o_RCC_* outputs keep their last values in IDLE. Only NewCommandOn qualifies them.

## Timing
- The FIFO is registered with no bypass. Handshake at edge N puts the entry in the FIFO at N. The pop happens at edge N+1 (IDLE→LAUNCH), and NewCommandOn rises at edge N+2.
- The o_RCC_* outputs are valid one cycle before NewCommandOn rises.
- Master_Done at edge M: NewCommandOn is low and req_done is high in the cycle after M. The next launch pop happens no earlier than M+1, and its NewCommandOn rises no earlier than M+2.
- Back-to-back commands have NewCommandOn low for at least 1 cycle between them.
- Reset asserted mid-transfer: all outputs go to 0 immediately. Queued and in-flight commands are discarded, and no req_done is issued.

## Structure
- ahb3lite_pkg gains:
  - typedef dma_cmd_t {logic [15:0] addr_high, addr_low; logic [5:0] len; logic [IDW-1:0] id;}
  - enum sched_state_e {S_IDLE, S_LAUNCH, S_BUSY}
  - localparam DMA_LEN_W = 6
- Sub-module dma_cmd_fifo: a parameterised dma_cmd_t FIFO with push/pop/full/empty/level. The arbiter and FSM stay in the top.

## Test plan
- **Single command.** Requester 0 sends {0x1234, 0x5678, len 8} with SystemStart=1. Required:
  - req_ready[0] is high for 1 cycle.
  - NewCommandOn rises 2 edges later, with o_RCC_* = 0x1234/0x5678/8 and o_active_id=0.
  - Master_Done 10 cycles later → NewCommandOn falls and req_done[0] pulses once.
- **Round robin.** req_valid=2'b11 held. Required: grants alternate 0,1,0,1 until fifo_level=4, then req_ready=0. Launch order matches grant order.
- **Zero length.** Requester 1 sends len 0. Required: NewCommandOn never rises, req_done[1] pulses one cycle after the pop, and the next queued command launches normally.
- **SystemStart gating.** Queue 2 commands with SystemStart=0. Required: NewCommandOn stays 0 and fifo_level=2. Raising SystemStart launches the first command 1 edge later.
- **Full FIFO with simultaneous push/pop.** With the FIFO full, pulse Master_Done so a new launch pops while requester 0 is valid. Required: a pop frees a slot, so fifo_level reaches 3, and the push is accepted on the next cycle without loss or duplication.
- **Reset mid-transfer.** Assert HRESET asynchronously during BUSY. Required: NewCommandOn=0, fifo_level=0 and req_done=0 before the next HCLK edge. After release the block idles until new requests arrive.
